// File: rtl/cpsd_pkg.sv
// Shared definitions for the CPSD rhythm path: class codes and the
// sequencing FSM state encoding.
package cpsd_pkg;

  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_AF     = 2'b01;
  localparam logic [1:0] CLS_VF     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_WAIT = 2'b10,
    ST_EVAL = 2'b11
  } state_e;

  // One-hot normal/AF/VF flags to the 2-bit class code; 11 is never produced.
  function automatic logic [1:0] encode_class(input logic is_n, input logic is_a,
                                              input logic is_v);
    logic [1:0] cls;
    unique case ({is_v, is_a, is_n})
      3'b100:  cls = CLS_VF;
      3'b010:  cls = CLS_AF;
      default: cls = CLS_NORMAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/thr_classify_ctrl_if.sv
// Sample handshake, threshold config, classification results and alarm
// for thr_classify_ctrl, plus the FSM state as a debug signal.
interface thr_classify_ctrl_if #(
  parameter int DATA_WIDTH = 16
) ();
  import cpsd_pkg::*;

  // Valid/ready: a sample transfers on a rising edge where x_valid and x_ready
  // are both 1; x_valid must not depend on x_ready, and x_ready is 1 only in
  // WAIT with no pending config and en high.
  logic                  en;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] xin;
  logic                  cfg_we;
  logic [DATA_WIDTH-1:0] cfg_thr1;
  logic [DATA_WIDTH-1:0] cfg_thr2;
  logic                  cfg_err;
  logic [1:0]            win_class;
  logic                  win_valid;
  logic [1:0]            rhythm;
  logic                  rhythm_chg;
  logic                  alarm;
  logic                  alarm_clr;
  state_e                dbg_state;

  modport slave (
    input  en, x_valid, xin, cfg_we, cfg_thr1, cfg_thr2, alarm_clr,
    output x_ready, cfg_err, win_class, win_valid, rhythm, rhythm_chg, alarm,
           dbg_state
  );

  modport master (
    output en, x_valid, xin, cfg_we, cfg_thr1, cfg_thr2, alarm_clr,
    input  x_ready, cfg_err, win_class, win_valid, rhythm, rhythm_chg, alarm,
           dbg_state
  );

endinterface

// File: rtl/thr_classify_ctrl_thresholding.sv
// Combinational two-threshold comparator: x<=thr1 normal, thr1<x<=thr2 AF,
// x>thr2 VF. All flags are low when disabled or held in reset.
module thresholding #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_thr1,
  input  logic [DATA_WIDTH-1:0] i_thr2,
  output logic                  o_normal,
  output logic                  o_af,
  output logic                  o_vf
);

  always_comb begin
    o_normal = 1'b0;
    o_af     = 1'b0;
    o_vf     = 1'b0;
    if (i_rstn && i_en) begin
      if (i_x > i_thr2)      o_vf     = 1'b1;
      else if (i_x > i_thr1) o_af     = 1'b1;
      else                   o_normal = 1'b1;
    end
  end

endmodule

// File: rtl/thr_classify_ctrl.sv
// Sequences the thresholding block: accepts one sample per window, classifies
// it, debounces the class into a confirmed rhythm and raises a sticky VF alarm.
module thr_classify_ctrl
  import cpsd_pkg::*;
#(
  parameter int                  DATA_WIDTH  = 16,
  parameter int                  CONFIRM_CNT = 4,
  parameter logic [DATA_WIDTH-1:0] THR1_RST  = 16'h0400,
  parameter logic [DATA_WIDTH-1:0] THR2_RST  = 16'h0800
) (
  input logic             clk,
  input logic             rst,
  thr_classify_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(CONFIRM_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                r_state;
  state_e                w_next;
  logic                  w_x_ready;
  logic [DATA_WIDTH-1:0] r_act1, r_act2, r_sh1, r_sh2, r_x;
  logic                  r_pend;
  logic [1:0]            r_win_class, r_rhythm, r_cand;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_win_valid, r_rhythm_chg, r_alarm, r_cfg_err;

  logic                  w_is_n, w_is_a, w_is_v;
  logic [1:0]            w_new_cls, w_cand_n;
  logic [CNT_W-1:0]      w_cnt_n;
  logic                  w_eval_done, w_change, w_cfg_ok, w_cfg_bad, w_accept;

  thresholding #(.DATA_WIDTH(DATA_WIDTH)) u_thr (
    .i_rstn   (~rst),
    .i_en     (r_state == ST_EVAL),
    .i_x      (r_x),
    .i_thr1   (r_act1),
    .i_thr2   (r_act2),
    .o_normal (w_is_n),
    .o_af     (w_is_a),
    .o_vf     (w_is_v)
  );

  assign w_cfg_ok    = bus.cfg_we && (bus.cfg_thr1 <= bus.cfg_thr2);
  assign w_cfg_bad   = bus.cfg_we && (bus.cfg_thr1 > bus.cfg_thr2);
  assign w_accept    = w_x_ready && bus.x_valid;
  assign w_eval_done = (r_state == ST_EVAL) && bus.en;
  assign w_new_cls   = encode_class(w_is_n, w_is_a, w_is_v);

  always_comb begin
    w_next    = r_state;
    w_x_ready = 1'b0;
    if (!bus.en) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: w_next = ST_LOAD;
        ST_LOAD: w_next = ST_WAIT;
        ST_WAIT: begin
          if (r_pend) begin
            w_next = ST_LOAD;
          end else begin
            w_x_ready = 1'b1;
            if (bus.x_valid) w_next = ST_EVAL;
          end
        end
        ST_EVAL: w_next = ST_WAIT;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Debounce candidate for the window finishing this cycle.
  always_comb begin
    w_cand_n = w_new_cls;
    w_cnt_n  = CNT_ONE;
    if (w_new_cls == r_cand) begin
      w_cand_n = r_cand;
      w_cnt_n  = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
    end
    w_change = w_eval_done && (w_cnt_n == CNT_MAX) && (w_cand_n != r_rhythm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_act1       <= THR1_RST;
      r_act2       <= THR2_RST;
      r_sh1        <= THR1_RST;
      r_sh2        <= THR2_RST;
      r_pend       <= 1'b0;
      r_x          <= '0;
      r_win_class  <= CLS_NORMAL;
      r_rhythm     <= CLS_NORMAL;
      r_cand       <= CLS_NORMAL;
      r_cnt        <= '0;
      r_win_valid  <= 1'b0;
      r_rhythm_chg <= 1'b0;
      r_alarm      <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cfg_err    <= w_cfg_bad;
      r_win_valid  <= w_eval_done;
      r_rhythm_chg <= w_change;
      // A write landing in LOAD keeps pend set so the new values get loaded too.
      if (w_cfg_ok) begin
        r_sh1  <= bus.cfg_thr1;
        r_sh2  <= bus.cfg_thr2;
        r_pend <= 1'b1;
      end else if (r_state == ST_LOAD) begin
        r_pend <= 1'b0;
      end
      if (r_state == ST_LOAD) begin
        r_act1 <= r_sh1;
        r_act2 <= r_sh2;
      end
      if (w_accept) r_x <= bus.xin;
      if (w_eval_done) begin
        r_win_class <= w_new_cls;
        r_cand      <= w_cand_n;
        r_cnt       <= w_cnt_n;
      end
      if (w_change) r_rhythm <= w_cand_n;
      if (w_change && (w_cand_n == CLS_VF))         r_alarm <= 1'b1;
      else if (bus.alarm_clr && (r_rhythm != CLS_VF)) r_alarm <= 1'b0;
    end
  end

  assign bus.x_ready    = w_x_ready;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.win_class  = r_win_class;
  assign bus.win_valid  = r_win_valid;
  assign bus.rhythm     = r_rhythm;
  assign bus.rhythm_chg = r_rhythm_chg;
  assign bus.alarm      = r_alarm;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_thr_classify_ctrl.sv
// Bench for thr_classify_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a window-level model.
module tb_thr_classify_ctrl;
  import cpsd_pkg::*;

  localparam int CC = 4;
  localparam logic [15:0] T1_RST = 16'h0400;
  localparam logic [15:0] T2_RST = 16'h0800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  thr_classify_ctrl_if #(.DATA_WIDTH(16)) bus ();

  thr_classify_ctrl #(.DATA_WIDTH(16), .CONFIRM_CNT(CC),
                      .THR1_RST(T1_RST), .THR2_RST(T2_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 loading thresholds, 2 waiting for a sample, 3 evaluating.
  bit          m_on = 0;
  int          m_phase;
  bit          m_pend;
  logic [15:0] m_sh1, m_sh2, m_a1, m_a2, m_x;
  logic [1:0]  hist[$];
  logic [1:0]  e_win_class, e_rhythm;
  logic        e_win_valid, e_chg, e_alarm, e_cfg_err;

  function automatic logic [1:0] classify(input logic [15:0] x, input logic [15:0] t1,
                                          input logic [15:0] t2);
    if (x > t2) return CLS_VF;
    if (x > t1) return CLS_AF;
    return CLS_NORMAL;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_pend = 0;
    m_sh1 = T1_RST; m_sh2 = T2_RST; m_a1 = T1_RST; m_a2 = T2_RST; m_x = '0;
    hist.delete();
    e_win_class = CLS_NORMAL; e_rhythm = CLS_NORMAL;
    e_win_valid = 0; e_chg = 0; e_alarm = 0; e_cfg_err = 0;
  endtask

  task automatic model_step();
    bit acc;
    int nxt;
    int streak;
    logic [1:0] c;
    bit clr_ok;
    acc = (m_phase == 2) && !m_pend && bus.en && bus.x_valid;
    clr_ok = bus.alarm_clr && (e_rhythm != CLS_VF);
    if (!bus.en) nxt = 0;
    else case (m_phase)
      0: nxt = 1;
      1: nxt = 2;
      2: nxt = m_pend ? 1 : (acc ? 3 : 2);
      default: nxt = 2;
    endcase
    e_win_valid = 0;
    e_chg = 0;
    e_cfg_err = bus.cfg_we && (bus.cfg_thr1 > bus.cfg_thr2);
    if (clr_ok) e_alarm = 0;
    if (m_phase == 3 && bus.en) begin
      c = classify(m_x, m_a1, m_a2);
      e_win_class = c;
      e_win_valid = 1;
      hist.push_back(c);
      if (hist.size() > CC) void'(hist.pop_front());
      streak = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != c) break;
        streak++;
      end
      if (streak == CC && c != e_rhythm) begin
        e_rhythm = c;
        e_chg = 1;
        if (c == CLS_VF) e_alarm = 1;
      end
    end
    if (m_phase == 1) begin
      m_a1 = m_sh1;
      m_a2 = m_sh2;
    end
    if (bus.cfg_we && bus.cfg_thr1 <= bus.cfg_thr2) begin
      m_sh1 = bus.cfg_thr1; m_sh2 = bus.cfg_thr2; m_pend = 1;
    end else if (m_phase == 1) begin
      m_pend = 0;
    end
    if (acc) m_x = bus.xin;
    m_phase = nxt;
  endtask

  // Compare on the falling edge, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (m_on) begin
      chk("x_ready", 16'(bus.x_ready), 16'(m_phase == 2 && !m_pend && bus.en));
      chk("win_valid", 16'(bus.win_valid), 16'(e_win_valid));
      chk("win_class", 16'(bus.win_class), 16'(e_win_class));
      chk("rhythm", 16'(bus.rhythm), 16'(e_rhythm));
      chk("rhythm_chg", 16'(bus.rhythm_chg), 16'(e_chg));
      chk("alarm", 16'(bus.alarm), 16'(e_alarm));
      chk("cfg_err", 16'(bus.cfg_err), 16'(e_cfg_err));
    end
    if (rst) begin
      model_reset();
      m_on = 1;
    end else if (m_on) begin
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1; bus.en = 0; bus.x_valid = 0; bus.cfg_we = 0; bus.alarm_clr = 0;
    tick(); tick();
    rst = 0;
  endtask

  // Offer one sample; optionally issue a config write during its EVAL cycle.
  task automatic send(input logic [15:0] x, input logic [1:0] exp_cls, input bit cfg_mid,
                      input logic [15:0] t1, input logic [15:0] t2);
    int n = 0;
    bus.x_valid = 1; bus.xin = x;
    while (!bus.x_ready && n < 20) begin tick(); n++; end
    if (n >= 20) begin
      chk("handshake_timeout", 16'(n), 16'(0));
      bus.x_valid = 0;
      return;
    end
    tick();
    bus.x_valid = 0;
    if (cfg_mid) begin bus.cfg_we = 1; bus.cfg_thr1 = t1; bus.cfg_thr2 = t2; end
    chk("lat_t1_no_valid", 16'(bus.win_valid), 16'(0));
    tick();
    bus.cfg_we = 0;
    chk("lat_t2_valid", 16'(bus.win_valid), 16'(1));
    chk("lit_class", 16'(bus.win_class), 16'(exp_cls));
  endtask

  task automatic send_n(input logic [15:0] x, input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) send(x, c, 0, 0, 0);
  endtask

  initial begin
    bus.en = 0; bus.x_valid = 0; bus.xin = '0; bus.cfg_we = 0;
    bus.cfg_thr1 = '0; bus.cfg_thr2 = '0; bus.alarm_clr = 0;
    do_reset();
    chk("rst_x_ready", 16'(bus.x_ready), 16'(0));
    chk("rst_rhythm", 16'(bus.rhythm), 16'(0));
    chk("rst_alarm", 16'(bus.alarm), 16'(0));

    // Boundaries around the reset thresholds.
    bus.en = 1;
    send(16'h0400, CLS_NORMAL, 0, 0, 0);
    send(16'h0401, CLS_AF, 0, 0, 0);
    send(16'h0800, CLS_AF, 0, 0, 0);
    send(16'h0801, CLS_VF, 0, 0, 0);

    // Three AF windows do not confirm; the fourth does, once.
    send_n(16'h0600, CLS_AF, 3);
    chk("af3_rhythm", 16'(bus.rhythm), 16'(CLS_NORMAL));
    send(16'h0600, CLS_AF, 0, 0, 0);
    chk("af4_rhythm", 16'(bus.rhythm), 16'(CLS_AF));
    chk("af4_chg", 16'(bus.rhythm_chg), 16'(1));
    send(16'h0600, CLS_AF, 0, 0, 0);
    chk("af5_no_chg", 16'(bus.rhythm_chg), 16'(0));

    // Streak broken by one normal window.
    do_reset();
    bus.en = 1;
    send_n(16'h0600, CLS_AF, 3);
    send(16'h0100, CLS_NORMAL, 0, 0, 0);
    send_n(16'h0600, CLS_AF, 3);
    chk("streak7_rhythm", 16'(bus.rhythm), 16'(CLS_NORMAL));
    send(16'h0600, CLS_AF, 0, 0, 0);
    chk("streak8_rhythm", 16'(bus.rhythm), 16'(CLS_AF));

    // Config write during EVAL is applied before the next accept.
    send(16'h0050, CLS_NORMAL, 1, 16'h0100, 16'h0200);
    chk("pend_blocks_ready", 16'(bus.x_ready), 16'(0));
    send(16'h0150, CLS_AF, 0, 0, 0);
    bus.cfg_we = 1; bus.cfg_thr1 = 16'h0300; bus.cfg_thr2 = 16'h0200;
    tick();
    bus.cfg_we = 0;
    chk("cfg_err_pulse", 16'(bus.cfg_err), 16'(1));
    tick();
    chk("cfg_err_clear", 16'(bus.cfg_err), 16'(0));
    send(16'h0250, CLS_VF, 0, 0, 0);

    // Sticky alarm.
    do_reset();
    bus.en = 1;
    send_n(16'h0900, CLS_VF, 4);
    chk("vf_alarm_set", 16'(bus.alarm), 16'(1));
    bus.alarm_clr = 1; tick(); bus.alarm_clr = 0;
    chk("alarm_clr_blocked", 16'(bus.alarm), 16'(1));
    send_n(16'h0100, CLS_NORMAL, 4);
    chk("normal_rhythm", 16'(bus.rhythm), 16'(CLS_NORMAL));
    chk("alarm_held", 16'(bus.alarm), 16'(1));
    bus.alarm_clr = 1; tick(); bus.alarm_clr = 0;
    chk("alarm_cleared", 16'(bus.alarm), 16'(0));

    // Abort an in-flight EVAL, restart, then reset mid-WAIT.
    begin
      int n = 0;
      bus.x_valid = 1; bus.xin = 16'h0900;
      while (!bus.x_ready && n < 20) begin tick(); n++; end
      chk("abort_ready_seen", 16'(n < 20), 16'(1));
      tick();
      bus.x_valid = 0;
      bus.en = 0;
      tick();
      chk("abort_no_valid", 16'(bus.win_valid), 16'(0));
      chk("abort_no_ready", 16'(bus.x_ready), 16'(0));
      bus.en = 1;
      tick();
      chk("restart_load", 16'(bus.dbg_state), 16'(ST_LOAD));
      tick();
      chk("restart_wait", 16'(bus.dbg_state), 16'(ST_WAIT));
      chk("restart_ready", 16'(bus.x_ready), 16'(1));
      chk("abort_rhythm_kept", 16'(bus.rhythm), 16'(CLS_NORMAL));
      rst = 1; tick(); rst = 0;
      chk("rst_state", 16'(bus.dbg_state), 16'(ST_IDLE));
      chk("rst_ready2", 16'(bus.x_ready), 16'(0));
      chk("rst_class", 16'(bus.win_class), 16'(0));
    end

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.en = ($urandom_range(0, 39) != 0);
      bus.x_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 7))
          0: bus.xin = m_a1 - 16'd1;
          1: bus.xin = m_a1;
          2: bus.xin = m_a1 + 16'd1;
          3: bus.xin = m_a2 - 16'd1;
          4: bus.xin = m_a2;
          5: bus.xin = m_a2 + 16'd1;
          default: bus.xin = 16'($urandom_range(0, 16'hFFFF));
        endcase
      end
      bus.cfg_we = ($urandom_range(0, 29) == 0);
      begin
        logic [15:0] t1, t2;
        t1 = 16'($urandom_range(0, 16'hC000));
        t2 = t1 + 16'($urandom_range(0, 16'h3000));
        if ($urandom_range(0, 3) == 0) begin
          bus.cfg_thr1 = t2 + 16'd1; bus.cfg_thr2 = t2;
        end else begin
          bus.cfg_thr1 = t1; bus.cfg_thr2 = t2;
        end
      end
      bus.alarm_clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 0; bus.en = 0; bus.x_valid = 0; bus.cfg_we = 0; bus.alarm_clr = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
